// File: rtl/btn_debounce_bank.sv
// btn_debounce_bank
//
// Multi-channel button debouncer. Every channel synchronises its raw input,
// waits until the synchronised value has disagreed with the debounced level
// for STABLE_CYCLES consecutive cycles, and then flips the level. Each channel
// also emits one-cycle press, release and long-hold event pulses, so the game
// logic downstream can consume events directly.
//
// Ports:
//   clk_i      system clock, rising edge
//   rst_ni     synchronous active-low reset
//   btn_i      raw asynchronous button inputs (1 = pressed)
//   btn_db_o   debounced level per channel
//   press_o    one-cycle pulse when a channel's debounced level rises
//   release_o  one-cycle pulse when a channel's debounced level falls
//   hold_o     one-cycle pulse after HOLD_CYCLES cycles of continuous press

module btn_debounce_bank #(
  parameter int N_BTN         = 4,
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 1000000,
  parameter int HOLD_CYCLES   = 50000000
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [N_BTN-1:0] btn_i,
  output logic [N_BTN-1:0] btn_db_o,
  output logic [N_BTN-1:0] press_o,
  output logic [N_BTN-1:0] release_o,
  output logic [N_BTN-1:0] hold_o
);

  localparam int CntW  = $clog2(STABLE_CYCLES + 1);
  localparam int HoldW = $clog2(HOLD_CYCLES + 1);

  localparam logic [CntW-1:0]  StableLast = CntW'(STABLE_CYCLES - 1);
  localparam logic [HoldW-1:0] HoldMax    = HoldW'(HOLD_CYCLES);
  localparam logic [HoldW-1:0] HoldPre    = HoldW'(HOLD_CYCLES - 1);

  // The FSM state doubles as the debounced level: Released = 0, Pressed = 1.
  typedef enum logic {
    Released = 1'b0,
    Pressed  = 1'b1
  } chanState_e;

  for (genvar i = 0; i < N_BTN; i++) begin : gChan
    logic [SYNC_STAGES-1:0] sync_q;
    logic [CntW-1:0]        stableCnt_q, stableCnt_d;
    logic [HoldW-1:0]       holdCnt_q, holdCnt_d;
    chanState_e             state_q, state_d;
    logic                   press_q, press_d;
    logic                   release_q, release_d;
    logic                   hold_q, hold_d;
    logic                   syncBtn;
    logic                   level;

    assign syncBtn = sync_q[SYNC_STAGES-1];
    assign level   = (state_q == Pressed);

    // Synchroniser shift register: the raw pin enters at bit 0 and the
    // last stage is the only value the debounce logic ever looks at.
    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        sync_q <= '0;
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], btn_i[i]};
      end
    end

    // Next-state logic. The stable counter only advances while the
    // synchronised input disagrees with the current level; a single cycle
    // of agreement clears it, so short bounces never reach the output.
    // Event pulses are computed from the upcoming transition so that they
    // are registered alongside the level flip. A release in the same cycle
    // the hold counter would saturate suppresses the hold pulse.
    always_comb begin
      state_d     = state_q;
      stableCnt_d = '0;
      holdCnt_d   = holdCnt_q;
      press_d     = 1'b0;
      release_d   = 1'b0;
      hold_d      = 1'b0;

      if (syncBtn != level) begin
        if (stableCnt_q == StableLast) begin
          state_d = level ? Released : Pressed;
        end else begin
          stableCnt_d = stableCnt_q + 1'b1;
        end
      end

      case (state_q)
        Released: begin
          holdCnt_d = '0;
          if (state_d == Pressed) begin
            press_d = 1'b1;
          end
        end
        Pressed: begin
          if (state_d == Released) begin
            release_d = 1'b1;
            holdCnt_d = '0;
          end else if (holdCnt_q != HoldMax) begin
            holdCnt_d = holdCnt_q + 1'b1;
            hold_d    = (holdCnt_q == HoldPre);
          end
        end
        default: begin
          state_d = Released;
        end
      endcase
    end

    // State, counters and event pulses all live in flops so no output has
    // a combinational path back to the pins.
    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        state_q     <= Released;
        stableCnt_q <= '0;
        holdCnt_q   <= '0;
        press_q     <= 1'b0;
        release_q   <= 1'b0;
        hold_q      <= 1'b0;
      end else begin
        state_q     <= state_d;
        stableCnt_q <= stableCnt_d;
        holdCnt_q   <= holdCnt_d;
        press_q     <= press_d;
        release_q   <= release_d;
        hold_q      <= hold_d;
      end
    end

    assign btn_db_o[i]  = level;
    assign press_o[i]   = press_q;
    assign release_o[i] = release_q;
    assign hold_o[i]    = hold_q;
  end

endmodule
